frame_timebase: RTL
===================

FRAME_TIMEBASE -- requirements
Module: frame_timebase

Interface
REQ-001 Parameter CNT_W, default 8: frame counter width, 5..16.
REQ-002 Parameter BLINK_BIT, default 4: frame_count bit driving cursorBlink; SHALL be < CNT_W.
REQ-003 Parameter VSYNC_POL, default 0: 0 counts vsync falling edges, 1 counts rising edges.
REQ-004 Parameter SYNC_STAGES, default 2: vsync synchroniser depth, 2..4.
REQ-005 Parameter RST_FRAMES, default 2: frame ticks before userResetn releases, 1..255.
REQ-006 Parameter KEY_FRAMES, default 8: frame ticks from key_restart to keyTimeout, 1..255.
REQ-007 Parameter WDOG_CYCLES, default 1048576: clk cycles without a frame tick before vsync_lost asserts, >= 4.
REQ-008 Reset resetn, synchronous, active-low; clock clk.
REQ-009 clk  in  1  system clock.
REQ-010 resetn  in  1  synchronous active-low reset.
REQ-011 vsync  in  1  asynchronous video vertical sync.
REQ-012 key_restart  in  1  single-cycle pulse restarting the key timer.
REQ-013 frame_tick  out  1  one-cycle pulse per counted vsync edge.
REQ-014 frame_count  out  CNT_W  free-running frame count.
REQ-015 cursorBlink  out  1  frame_count[BLINK_BIT].
REQ-016 keyTimeout  out  1  high once KEY_FRAMES ticks elapse since last restart.
REQ-017 vsync_lost  out  1  high while no tick seen for WDOG_CYCLES cycles.
REQ-018 userResetn  out  1  sticky system-release signal, low from reset until released.

Function
REQ-019 vsync SHALL pass through SYNC_STAGES flops; a further register holds the previous synchronised value for edge detection.
REQ-020 frame_tick SHALL be registered, high for exactly one cycle after clk edge SYNC_STAGES+1, counting the first edge that samples the new vsync level as edge 1.
REQ-021 Only the VSYNC_POL-selected edge SHALL produce frame_tick; the opposite edge produces nothing.
REQ-022 frame_count SHALL increment by 1 on each frame_tick and wrap from 2^CNT_W-1 to 0.
REQ-023 cursorBlink SHALL be combinational from frame_count[BLINK_BIT].
REQ-024 Key timer: key_restart clears the count to 0 and keyTimeout to 0 on the next edge; each frame_tick increments the count, saturating at KEY_FRAMES; keyTimeout is 1 when count == KEY_FRAMES.
REQ-025 key_restart and frame_tick in the same cycle: restart wins, count = 0.
REQ-026 Watchdog: cycle counter cleared by frame_tick, else +1, saturating at WDOG_CYCLES; vsync_lost registered, 1 when counter == WDOG_CYCLES.
REQ-027 frame_tick on a saturated watchdog SHALL clear the counter and vsync_lost on the same edge.
REQ-028 Release counter SHALL count frame_ticks, saturating at RST_FRAMES; userResetn sets to 1 on the edge the count reaches RST_FRAMES or on any cycle vsync_lost is 1.
REQ-029 userResetn, once 1, SHALL stay 1 until resetn is asserted.

Reset
REQ-030 resetn low SHALL take effect on the next clk edge regardless of state, including mid-count and mid-synchronisation.
REQ-031 Reset values: frame_tick 0, frame_count 0, keyTimeout 0, key count 0, vsync_lost 0, watchdog 0, release count 0, userResetn 0.
REQ-032 Synchroniser and previous-value flops SHALL reset to the post-edge level (VSYNC_POL = 0: 0; VSYNC_POL = 1: 1), so no tick occurs until a full opposite-then-active transition.

Verification
Bench parameters: CNT_W=5, BLINK_BIT=1, VSYNC_POL=0, SYNC_STAGES=2, RST_FRAMES=2, KEY_FRAMES=3, WDOG_CYCLES=16.
REQ-033 vsync 1 for 4 cycles after reset, then 0 -> frame_tick high after edge 3 from first sampled 0, for one cycle; frame_count=1; no tick on the rising edge.
REQ-034 Two vsync falling edges -> userResetn 0 after the first tick, 1 on the second tick's edge; still 1 after 40 further ticks.
REQ-035 key_restart, then 3 ticks -> keyTimeout rises on the 3rd tick edge; key_restart coincident with a tick -> keyTimeout 0, 3 more ticks needed.
REQ-036 vsync held low 16 cycles after the last tick -> vsync_lost=1 and userResetn=1 with 0 ticks; next falling edge -> vsync_lost=0 on the tick edge.
REQ-037 33 ticks -> frame_count wraps 31 -> 0 -> 1; cursorBlink toggles every 2 ticks.
REQ-038 resetn pulsed low during the 2nd synchroniser stage of a pending edge -> no frame_tick; all outputs at reset values.

Source files
------------

// File: rtl/frame_timebase.sv
// -----------------------------------------------------------------------------
// frame_timebase
//
// Derives a frame-rate timebase from an asynchronous video vsync. The vsync
// input is synchronised, and the selected edge becomes a one-cycle frame_tick.
// The tick drives several frame-based functions:
//   - a free-running frame counter, with a cursor blink tap taken from it
//   - a key-repeat timer, restarted by key_restart
//   - a watchdog that flags a lost vsync when no tick is seen for a while
//   - a sticky user reset release, after a few frames or on a lost vsync
//
// Ports
//   clk          in   system clock
//   resetn       in   synchronous, active-low reset
//   vsync        in   asynchronous vertical sync
//   key_restart  in   single-cycle pulse that restarts the key timer
//   frame_tick   out  one-cycle pulse per counted vsync edge
//   frame_count  out  free-running frame count, CNT_W bits
//   cursorBlink  out  frame_count[BLINK_BIT]
//   keyTimeout   out  high once KEY_FRAMES ticks have elapsed since a restart
//   vsync_lost   out  high while no tick has been seen for WDOG_CYCLES cycles
//   userResetn   out  sticky release; low from reset until released
//
// Every frame-driven register uses the combinational tick (tick_d). That tick
// is registered into frame_tick on the same edge, so each counter update
// becomes visible in the cycle where frame_tick is high.
// -----------------------------------------------------------------------------
module frame_timebase #(
  parameter int CNT_W       = 8,        // frame counter width, 5..16
  parameter int BLINK_BIT   = 4,        // frame_count bit used for cursorBlink
  parameter int VSYNC_POL   = 0,        // 0: count falling edges, 1: rising
  parameter int SYNC_STAGES = 2,        // synchroniser depth, 2..4
  parameter int RST_FRAMES  = 2,        // ticks before userResetn releases
  parameter int KEY_FRAMES  = 8,        // ticks from key_restart to keyTimeout
  parameter int WDOG_CYCLES = 1048576   // idle cycles before vsync_lost
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             vsync,
  input  logic             key_restart,
  output logic             frame_tick,
  output logic [CNT_W-1:0] frame_count,
  output logic             cursorBlink,
  output logic             keyTimeout,
  output logic             vsync_lost,
  output logic             userResetn
);

  // Level that vsync sits at after a counted edge. The synchroniser resets to
  // this level. As a result, the first tick after reset needs a full
  // opposite-then-active transition.
  localparam logic                   POST_LVL = (VSYNC_POL != 0);
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{POST_LVL}};

  localparam logic [7:0] KEY_MAX = 8'(KEY_FRAMES);
  localparam logic [7:0] REL_MAX = 8'(RST_FRAMES);

  localparam int             WD_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q,        sync_d;
  logic                   prev_q,        prev_d;
  logic                   frame_tick_q,  frame_tick_d;
  logic [CNT_W-1:0]       frame_count_q, frame_count_d;
  logic [7:0]             key_cnt_q,     key_cnt_d;
  logic                   key_timeout_q, key_timeout_d;
  logic [WD_W-1:0]        wdog_q,        wdog_d;
  logic                   vsync_lost_q,  vsync_lost_d;
  logic [7:0]             rel_cnt_q,     rel_cnt_d;
  logic                   user_resetn_q, user_resetn_d;

  logic sync_new;
  logic tick_d;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detect
  // ---------------------------------------------------------------------------
  // sync_q[0] is the first stage. The last stage is compared against prev_q.
  // The tick is registered one edge after the last stage updates. This places
  // frame_tick high after edge SYNC_STAGES+1.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], vsync};
    sync_new = sync_q[SYNC_STAGES-1];
    prev_d   = sync_new;
    tick_d   = (sync_new == POST_LVL) && (prev_q != POST_LVL);
    frame_tick_d = tick_d;
  end

  // ---------------------------------------------------------------------------
  // Frame counter (wraps naturally)
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_count_d = frame_count_q;
    if (tick_d) begin
      frame_count_d = frame_count_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Key timer: a restart beats a coincident tick
  // ---------------------------------------------------------------------------
  always_comb begin
    key_cnt_d = key_cnt_q;
    if (key_restart) begin
      key_cnt_d = '0;
    end else if (tick_d && (key_cnt_q != KEY_MAX)) begin
      key_cnt_d = key_cnt_q + 8'd1;
    end
    key_timeout_d = (key_cnt_d == KEY_MAX);
  end

  // ---------------------------------------------------------------------------
  // Watchdog: a tick clears it, even from saturation, on the same edge
  // ---------------------------------------------------------------------------
  always_comb begin
    wdog_d = wdog_q;
    if (tick_d) begin
      wdog_d = '0;
    end else if (wdog_q != WD_MAX) begin
      wdog_d = wdog_q + WD_W'(1);
    end
    vsync_lost_d = (wdog_d == WD_MAX);
  end

  // ---------------------------------------------------------------------------
  // User reset release
  // ---------------------------------------------------------------------------
  // The release is sticky. A lost vsync also releases, so that a system with
  // no video does not stay held in reset forever.
  always_comb begin
    rel_cnt_d = rel_cnt_q;
    if (tick_d && (rel_cnt_q != REL_MAX)) begin
      rel_cnt_d = rel_cnt_q + 8'd1;
    end
    user_resetn_d = user_resetn_q || (rel_cnt_d == REL_MAX) || vsync_lost_d;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q        <= SYNC_RST;
      prev_q        <= POST_LVL;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
      key_cnt_q     <= '0;
      key_timeout_q <= 1'b0;
      wdog_q        <= '0;
      vsync_lost_q  <= 1'b0;
      rel_cnt_q     <= '0;
      user_resetn_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
      key_cnt_q     <= key_cnt_d;
      key_timeout_q <= key_timeout_d;
      wdog_q        <= wdog_d;
      vsync_lost_q  <= vsync_lost_d;
      rel_cnt_q     <= rel_cnt_d;
      user_resetn_q <= user_resetn_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;
  assign cursorBlink = frame_count_q[BLINK_BIT];
  assign keyTimeout  = key_timeout_q;
  assign vsync_lost  = vsync_lost_q;
  assign userResetn  = user_resetn_q;

endmodule
